// File: rtl/pwm_duty_update_scheduler_if.sv
// Sample handshake bundle for pwm_duty_update_scheduler.
// Source drives valid/data, scheduler returns ready.
interface pwm_duty_update_scheduler_if #(
  parameter int WIDTH = 13
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic             sample_ready;

  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready
  );
endinterface

// File: rtl/pwm_duty_update_scheduler.sv
// Distance-to-PWM sequencer: averages samples, makes the PWM tick,
// and commits duty_cycle only on PWM period boundaries.
module pwm_duty_update_scheduler #(
  parameter int WIDTH     = 13,
  parameter int MAX_COUNT = 3000,
  parameter int PRESCALE  = 50,
  parameter int AVG_LOG2  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_duty_update_scheduler_if.slave s_if,
  input  logic                  freeze,
  output logic                  pwm_enable,
  output logic                  period_start,
  output logic [WIDTH-1:0]      duty_cycle,
  output logic                  update_pending,
  output logic                  overrange
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PC_W  = $clog2(MAX_COUNT + 1);
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    ACCUM,
    PENDING
  } state_t;

  state_t           r_state;
  logic [PS_W-1:0]  r_ps;
  logic             r_en;
  logic [PC_W-1:0]  r_pc;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bovr;
  logic [WIDTH-1:0] r_avg;
  logic [WIDTH-1:0] r_duty;
  logic             r_ovr;
  logic             r_ready;
  logic             r_pend;

  logic             w_ps;
  logic             w_take;
  logic             w_over;
  logic [WIDTH-1:0] w_s;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_shift;
  logic [WIDTH-1:0] w_avg;

  assign w_ps    = r_en && (r_pc == PC_LAST);
  assign w_take  = s_if.sample_valid && r_ready;
  assign w_over  = s_if.sample_data > MAX_W;
  assign w_s     = w_over ? MAX_W : s_if.sample_data;
  assign w_sum   = r_acc + ACC_W'(w_s);
  assign w_shift = w_sum >> AVG_LOG2;
  assign w_avg   = w_shift[WIDTH-1:0];

  assign s_if.sample_ready = r_ready;
  assign pwm_enable        = r_en;
  assign period_start      = w_ps;
  assign duty_cycle        = r_duty;
  assign update_pending    = r_pend;
  assign overrange         = r_ovr;

  // Prescaler: one registered enable tick per PRESCALE clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps <= '0;
      r_en <= 1'b0;
    end else begin
      r_en <= (r_ps == PS_LAST);
      if (r_ps == PS_LAST)
        r_ps <= '0;
      else
        r_ps <= r_ps + 1'b1;
    end
  end

  // Period counter: 0..MAX_COUNT in enable ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (r_en) begin
      if (r_pc == PC_LAST)
        r_pc <= '0;
      else
        r_pc <= r_pc + 1'b1;
    end
  end

  // Batch/commit FSM: accumulate, then hold avg until a free boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bovr  <= 1'b0;
      r_avg   <= '0;
      r_duty  <= '0;
      r_ovr   <= 1'b0;
      r_ready <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          r_ready <= 1'b1;
          if (w_take) begin
            r_acc  <= w_sum;
            r_bovr <= r_bovr | w_over;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= PENDING;
              r_avg   <= w_avg;
              r_ready <= 1'b0;
              r_pend  <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (w_ps && !freeze) begin
            r_duty  <= r_avg;
            r_ovr   <= r_bovr;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bovr  <= 1'b0;
            r_state <= ACCUM;
            r_ready <= 1'b1;
            r_pend  <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_update_scheduler.sv
// Directed bench for pwm_duty_update_scheduler.
// Two instances: averaged/prescaled and pass-through/unprescaled.
module tb_pwm_duty_update_scheduler;

  localparam int W = 13;

  logic clk;
  logic reset1, reset2;
  logic freeze1, freeze2;
  logic en1, ps1, pend1, ovr1;
  logic en2, ps2, pend2, ovr2;
  logic [W-1:0] duty1, duty2;

  int checks;
  int errors;

  pwm_duty_update_scheduler_if #(.WIDTH(W)) if1 ();
  pwm_duty_update_scheduler_if #(.WIDTH(W)) if2 ();

  pwm_duty_update_scheduler #(
    .WIDTH(W), .MAX_COUNT(9), .PRESCALE(2), .AVG_LOG2(2)
  ) u_dut1 (
    .clk           (clk),
    .reset         (reset1),
    .s_if          (if1.slave),
    .freeze        (freeze1),
    .pwm_enable    (en1),
    .period_start  (ps1),
    .duty_cycle    (duty1),
    .update_pending(pend1),
    .overrange     (ovr1)
  );

  pwm_duty_update_scheduler #(
    .WIDTH(W), .MAX_COUNT(9), .PRESCALE(1), .AVG_LOG2(0)
  ) u_dut2 (
    .clk           (clk),
    .reset         (reset2),
    .s_if          (if2.slave),
    .freeze        (freeze2),
    .pwm_enable    (en2),
    .period_start  (ps2),
    .duty_cycle    (duty2),
    .update_pending(pend2),
    .overrange     (ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic send1(input int v);
    bit ok;
    int k;
    ok = 0;
    k = 0;
    if1.sample_data  = W'(v);
    if1.sample_valid = 1'b1;
    while (!ok && k < 200) begin
      if (if1.sample_ready) ok = 1;
      @(negedge clk);
      k++;
    end
    if1.sample_valid = 1'b0;
    if (!ok) chk("send1_timeout", 0, 1);
  endtask

  task automatic send2(input int v);
    bit ok;
    int k;
    ok = 0;
    k = 0;
    if2.sample_data  = W'(v);
    if2.sample_valid = 1'b1;
    while (!ok && k < 200) begin
      if (if2.sample_ready) ok = 1;
      @(negedge clk);
      k++;
    end
    if2.sample_valid = 1'b0;
    if (!ok) chk("send2_timeout", 0, 1);
  endtask

  task automatic wait_ps1(input int old, input string tag);
    bit seen;
    int k;
    seen = 0;
    k = 0;
    while (!seen && k < 200) begin
      if (ps1) begin
        seen = 1;
        chk({tag, "_hold"}, 32'(duty1), old);
      end
      @(negedge clk);
      k++;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ps2(input int old, input string tag);
    bit seen;
    int k;
    seen = 0;
    k = 0;
    while (!seen && k < 200) begin
      if (ps2) begin
        seen = 1;
        chk({tag, "_hold"}, 32'(duty2), old);
      end
      @(negedge clk);
      k++;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic gap1(output int n);
    int k;
    k = 0;
    while (!ps1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n = 1;
    while (!ps1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic gap2(output int n);
    int k;
    k = 0;
    while (!ps2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n = 1;
    while (!ps2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset1 = 1'b1;
    reset2 = 1'b1;
    freeze1 = 1'b0;
    freeze2 = 1'b0;
    if1.sample_valid = 1'b0;
    if1.sample_data  = '0;
    if2.sample_valid = 1'b0;
    if2.sample_data  = '0;

    // 1: reset state and tick/period cadence
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty1), 0);
    chk("rst_en", 32'(en1), 0);
    chk("rst_ps", 32'(ps1), 0);
    chk("rst_pend", 32'(pend1), 0);
    chk("rst_ovr", 32'(ovr1), 0);
    chk("rst_ready", 32'(if1.sample_ready), 0);
    reset1 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en1) n++;
    end
    chk("en_count", n, 10);
    gap1(n);
    chk("period_gap", n, 20);

    // 2: plain average
    send1(4); send1(5); send1(6); send1(7);
    chk("t2_pend", 32'(pend1), 1);
    chk("t2_rdy_lo", 32'(if1.sample_ready), 0);
    wait_ps1(0, "t2");
    chk("t2_duty", 32'(duty1), 5);
    chk("t2_rdy_hi", 32'(if1.sample_ready), 1);
    chk("t2_pend_clr", 32'(pend1), 0);
    chk("t2_ovr", 32'(ovr1), 0);
    gap1(n);
    chk("t2_gap", n, 20);

    // 3: clamp and overrange, then clean batch
    send1(12); send1(9); send1(9); send1(2);
    wait_ps1(5, "t3a");
    chk("t3a_duty", 32'(duty1), 7);
    chk("t3a_ovr", 32'(ovr1), 1);
    send1(1); send1(1); send1(1); send1(1);
    wait_ps1(7, "t3b");
    chk("t3b_duty", 32'(duty1), 1);
    chk("t3b_ovr", 32'(ovr1), 0);

    // 4: freeze holds pending value across boundaries
    freeze1 = 1'b1;
    send1(8); send1(8); send1(8); send1(8);
    chk("t4_pend", 32'(pend1), 1);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ps1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("t4_frz_duty", 32'(duty1), 1);
      chk("t4_frz_rdy", 32'(if1.sample_ready), 0);
      @(negedge clk);
    end
    chk("t4_frz_pend", 32'(pend1), 1);
    chk("t4_frz_after", 32'(duty1), 1);
    freeze1 = 1'b0;
    wait_ps1(1, "t4");
    chk("t4_duty", 32'(duty1), 8);
    chk("t4_pend_clr", 32'(pend1), 0);

    // 5: reset mid-batch discards partial samples
    send1(2); send1(2);
    reset1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_duty", 32'(duty1), 0);
    chk("t5_rst_pend", 32'(pend1), 0);
    reset1 = 1'b0;
    send1(4); send1(4); send1(4); send1(4);
    wait_ps1(0, "t5");
    chk("t5_duty", 32'(duty1), 4);

    // 6: no prescale, no averaging
    reset2 = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (en2) n++;
      @(negedge clk);
    end
    chk("t6_en_high", n, 10);
    gap2(n);
    chk("t6_gap", n, 10);
    send2(3);
    chk("t6_pend", 32'(pend2), 1);
    wait_ps2(0, "t6");
    chk("t6_duty", 32'(duty2), 3);
    chk("t6_pend_clr", 32'(pend2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
